mem_stage_lsu: RTL

MEM-stage load/store initiator for the pipelined MIPS core. It accepts one load or store per transaction from the EX/MEM register and drives the data-memory port: word address, lane-replicated write data, byte enables and read/write strobes. It waits for a variable-latency acknowledge, then returns sign- or zero-extended load data to MEM/WB. It stalls the pipeline while busy and reports alignment, size and bus-timeout errors.

---
 rtl/mem_stage_lsu_pkg.sv | 23 ++
 rtl/mem_stage_lsu_lane_align.sv | 50 +++++
 rtl/mem_stage_lsu.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared encodings for the MEM-stage load/store unit.
// Holds the access-size and error codes and the controller state enum.
package mem_stage_lsu_pkg;

    // Access size as carried by req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Error code returned on resp_err
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for the load/store unit.
// Produces little-endian byte enables, lane-replicated store data and the
// extracted, sign/zero-extended load value for a given size and offset.
// The offset is expected to be already aligned for the access size.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Steer lanes by size: enables, store replication and load extension
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {offset[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store initiator with variable-latency ack.
// Optional feature macro: MEM_STAGE_LSU_ALIGN_TRAP_EN. When defined, a
// misaligned half/word request is rejected with an alignment error; when
// undefined, the low address bits are aligned down and the access proceeds.
// Handshake: a request is taken on a cycle where req_valid and req_ready are
// both high; req_ready is only high in IDLE, and req_* are ignored otherwise.
// The memory side holds mem_req and all mem_* outputs stable until mem_ack.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_rd,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic [1:0]        resp_err,
    output logic              stall,
    output lsu_state_e        dbg_state
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;
    logic [7:0]  tmo_cnt;

    logic        accept;
    logic        in_idle;
    logic [1:0]  eff_off;
    logic        early_err;
    logic [1:0]  early_code;

    logic [1:0]  la_size;
    logic        la_signed;
    logic [1:0]  la_off;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;

    assign accept    = req_valid & req_ready;
    assign in_idle   = (state == ST_IDLE);
    assign dbg_state = state;

`ifdef MEM_STAGE_LSU_ALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign eff_off    = req_addr[1:0];
    assign early_err  = (req_size == SZ_ILL) || misaligned;
    assign early_code = (req_size == SZ_ILL) ? ERR_SIZE : ERR_ALIGN;
`else
    // Align the offset down to the access size instead of trapping
    always_comb begin
        case (req_size)
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
    end
    assign early_err  = (req_size == SZ_ILL);
    assign early_code = ERR_SIZE;
`endif

    // Idle steers the incoming request; busy states use the latched fields
    assign la_size   = in_idle ? req_size   : lat_size;
    assign la_signed = in_idle ? req_signed : lat_signed;
    assign la_off    = in_idle ? eff_off    : lat_off;

    lsu_lane_align u_lane_align (
        .size      (la_size),
        .sign_ext  (la_signed),
        .offset    (la_off),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (la_be),
        .wdata_rep (la_wdata),
        .rdata_ext (la_rdata)
    );

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_rd    <= 5'd0;
            resp_err   <= ERR_NONE;
            stall      <= 1'b0;
            tmo_cnt    <= 8'd0;
            lat_we     <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_signed <= 1'b0;
            lat_off    <= 2'b00;
            lat_rd     <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    if (accept) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= eff_off;
                        lat_rd     <= req_rd;
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        tmo_cnt    <= 8'd0;
                        if (early_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= early_code;
                            resp_rdata <= 32'h0;
                            resp_rd    <= req_rd;
                        end else begin
                            state     <= ST_WAIT;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_rd    <= ~req_we;
                            mem_addr  <= req_addr[ADDR_W-1:2];
                            mem_be    <= la_be;
                            mem_wdata <= req_we ? la_wdata : 32'h0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state      <= ST_RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_rd     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_NONE;
                        resp_rdata <= lat_we ? 32'h0 : la_rdata;
                        resp_rd    <= lat_rd;
                        tmo_cnt    <= 8'd0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= ST_RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_rd     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_BUS;
                        resp_rdata <= 32'h0;
                        resp_rd    <= lat_rd;
                        tmo_cnt    <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    stall      <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
